// File: rtl/counter_op_sched_pkg.sv
// Shared opcode constants, FSM state encoding and repeat-field width for the
// counter operation scheduler.
package counter_op_sched_pkg;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_SHR  = 2'b11;

  localparam int REP_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_FIN   = 2'd2
  } state_t;

endpackage

// File: rtl/counter_op_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping mod N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win_oh,
  output logic [PW-1:0] win_idx,
  output logic          win_vld
);

  logic [PW-1:0] idx;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = PW'((32'(ptr) + i) % N);
      if (!win_vld && req[idx]) begin
        win_vld     = 1'b1;
        win_oh[idx] = 1'b1;
        win_idx     = idx;
      end
    end
  end

endmodule

// File: rtl/counter_op_sched.sv
// Round-robin scheduler sharing one 4-bit load/inc/shift counter among N
// requesters; issues the granted operation REP+1 times (LOAD once).
module counter_op_sched
  import counter_op_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic                 C,
  input  logic                 RST,
  input  logic [N-1:0]         REQ,
  input  logic [2*N-1:0]       OP,
  input  logic [4*N-1:0]       DIN,
  input  logic [REP_W*N-1:0]   REP,
  input  logic [3:0]           Q,
  output logic [N-1:0]         GNT,
  output logic [N-1:0]         DONE,
  output logic                 OVF,
  output logic                 BUSY,
  output logic [3:0]           D,
  output logic                 L,
  output logic                 INC,
  output logic                 SHL,
  output logic                 SHR
);

  logic [1:0]       op_arr  [N];
  logic [3:0]       din_arr [N];
  logic [REP_W-1:0] rep_arr [N];

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign op_arr[g]  = OP[2*g +: 2];
    assign din_arr[g] = DIN[4*g +: 4];
    assign rep_arr[g] = REP[REP_W*g +: REP_W];
  end

  state_t           state;
  logic [PW-1:0]    ptr;
  logic [REP_W-1:0] cnt;
  logic [N-1:0]     win_q;
  logic             ovf_acc;

  logic [N-1:0]     win_oh;
  logic [PW-1:0]    win_idx;
  logic             win_vld;
  logic [1:0]       win_op;
  logic [PW-1:0]    ptr_nxt;
  logic             ovf_hit;

  rr_arbiter #(.N(N), .PW(PW)) u_arb (
    .req     (REQ),
    .ptr     (ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .win_vld (win_vld)
  );

  assign win_op  = op_arr[win_idx];
  assign ptr_nxt = (win_idx == PW'(N - 1)) ? '0 : win_idx + 1'b1;
  assign ovf_hit = INC && (Q == 4'hF);

  // The control-line registers double as the latched opcode and D as the
  // latched data, so L alone marks a LOAD while issuing.
  always_ff @(posedge C) begin
    if (RST) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      cnt     <= '0;
      win_q   <= '0;
      ovf_acc <= 1'b0;
      GNT     <= '0;
      DONE    <= '0;
      OVF     <= 1'b0;
      BUSY    <= 1'b0;
      D       <= '0;
      L       <= 1'b0;
      INC     <= 1'b0;
      SHL     <= 1'b0;
      SHR     <= 1'b0;
    end else begin
      GNT  <= '0;
      DONE <= '0;
      OVF  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (win_vld) begin
            state <= ST_ISSUE;
            BUSY  <= 1'b1;
            GNT   <= win_oh;
            win_q <= win_oh;
            ptr   <= ptr_nxt;
            cnt   <= rep_arr[win_idx];
            D     <= din_arr[win_idx];
            L     <= (win_op == OP_LOAD);
            INC   <= (win_op == OP_INC);
            SHL   <= (win_op == OP_SHL);
            SHR   <= (win_op == OP_SHR);
          end
        end
        ST_ISSUE: begin
          if (L || cnt == '0) begin
            // Accumulator is folded into OVF and cleared on entry to FIN.
            state   <= ST_FIN;
            DONE    <= win_q;
            OVF     <= ovf_acc | ovf_hit;
            ovf_acc <= 1'b0;
            D       <= '0;
            L       <= 1'b0;
            INC     <= 1'b0;
            SHL     <= 1'b0;
            SHR     <= 1'b0;
          end else begin
            cnt     <= cnt - 1'b1;
            ovf_acc <= ovf_acc | ovf_hit;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_op_sched.sv
// Randomized bench for counter_op_sched with a transaction-level reference
// model and a behavioural 4-bit counter closing the Q feedback loop.
module tb_counter_op_sched;

  localparam int N  = 4;
  localparam int PW = 2;

  logic           C   = 1'b0;
  logic           RST = 1'b1;
  logic [N-1:0]   REQ = '0;
  logic [2*N-1:0] OP  = '0;
  logic [4*N-1:0] DIN = '0;
  logic [3*N-1:0] REP = '0;
  logic [3:0]     Q;
  logic [N-1:0]   GNT, DONE;
  logic           OVF, BUSY;
  logic [3:0]     D;
  logic           L, INC, SHL, SHR;

  logic [3:0]     q = 4'h0;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned mp       = 0;

  counter_op_sched #(.N(N), .PW(PW)) dut (
    .C    (C),
    .RST  (RST),
    .REQ  (REQ),
    .OP   (OP),
    .DIN  (DIN),
    .REP  (REP),
    .Q    (Q),
    .GNT  (GNT),
    .DONE (DONE),
    .OVF  (OVF),
    .BUSY (BUSY),
    .D    (D),
    .L    (L),
    .INC  (INC),
    .SHL  (SHL),
    .SHR  (SHR)
  );

  always #5 C = ~C;

  assign Q = q;

  // The shared counter instance; it is not reset by the scheduler's reset.
  always @(posedge C) begin
    if (L)        q <= D;
    else if (INC) q <= q + 4'd1;
    else if (SHL) q <= {q[2:0], D[0]};
    else if (SHR) q <= {D[3], q[3:1]};
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Counter value after k issues of op starting from q0.
  function automatic int unsigned model_q(input int unsigned op, input int unsigned q0,
                                          input int unsigned din, input int unsigned k);
    int unsigned fill;
    case (op)
      0: return (k == 0) ? q0 : din;
      1: return (q0 + k) % 16;
      2: begin
        fill = ((din & 1) != 0) ? (((1 << k) - 1) & 15) : 0;
        return ((q0 << k) | fill) & 15;
      end
      default: begin
        fill = ((din & 8) != 0) ? (15 & ~(15 >> k)) : 0;
        return (q0 >> k) | fill;
      end
    endcase
  endfunction

  // Called at a negedge of an IDLE cycle; returns at the negedge of the next
  // IDLE cycle so calls can run back-to-back at minimum spacing.
  task automatic do_txn(input logic [N-1:0] req, input logic [2*N-1:0] op_p,
                        input logic [4*N-1:0] din_p, input logic [3*N-1:0] rep_p,
                        input bit scramble, input int unsigned rst_at);
    int unsigned w, n, op, din, rep, q0, ovf, ctrl, kq;
    logic [N-1:0] w_oh;
    REQ = req; OP = op_p; DIN = din_p; REP = rep_p;
    w = N;
    for (int unsigned i = 0; i < N; i++) begin
      int unsigned j = (mp + i) % N;
      if (w == N && req[j]) w = j;
    end
    if (w == N) begin
      check("nowinner", 0, 1);
      return;
    end
    op   = (op_p  >> (2 * w)) & 3;
    din  = (din_p >> (4 * w)) & 15;
    rep  = (rep_p >> (3 * w)) & 7;
    n    = (op == 0) ? 1 : rep + 1;
    q0   = q;
    ovf  = (op == 1 && q0 + n >= 16) ? 1 : 0;
    ctrl = 8 >> op;
    w_oh = '0;
    w_oh[w] = 1'b1;
    mp = (w + 1) % N;
    for (int unsigned c = 1; c <= n + 2; c++) begin
      @(negedge C);
      kq = (c - 1 < n) ? c - 1 : n;
      check("gnt",  GNT,  (c == 1) ? w_oh : 0);
      check("ctrl", {L, INC, SHL, SHR}, (c <= n) ? ctrl : 0);
      check("d",    D,    (c <= n) ? din : 0);
      check("done", DONE, (c == n + 1) ? w_oh : 0);
      check("ovf",  OVF,  (c == n + 1) ? ovf : 0);
      check("busy", BUSY, (c <= n + 1) ? 1 : 0);
      check("q",    Q,    model_q(op, q0, din, kq));
      if (c == rst_at) begin
        RST = 1'b1;
        REQ = '0;
        @(negedge C);
        check("rst_outs", {GNT, DONE, OVF, BUSY, D, L, INC, SHL, SHR}, 0);
        check("rst_q", Q, model_q(op, q0, din, c));
        mp  = 0;
        RST = 1'b0;
        for (int unsigned j = 0; j < 3; j++) begin
          @(negedge C);
          check("rst_nodone", {GNT, DONE, BUSY}, 0);
        end
        return;
      end
      if (scramble && c <= n + 1) begin
        REQ = N'($urandom);
        OP  = (2*N)'($urandom);
        DIN = (4*N)'($urandom);
        REP = (3*N)'($urandom);
      end
      if (c == n + 2) REQ = '0;
    end
  endtask

  task automatic txn(input int unsigned who, input int unsigned op, input int unsigned din,
                     input int unsigned rep, input bit scramble, input int unsigned rst_at);
    logic [N-1:0]   req;
    logic [2*N-1:0] op_p;
    logic [4*N-1:0] din_p;
    logic [3*N-1:0] rep_p;
    op_p  = (2*N)'($urandom);
    din_p = (4*N)'($urandom);
    rep_p = (3*N)'($urandom);
    for (int unsigned b = 0; b < 2; b++) op_p[2*who + b]  = op[b];
    for (int unsigned b = 0; b < 4; b++) din_p[4*who + b] = din[b];
    for (int unsigned b = 0; b < 3; b++) rep_p[3*who + b] = rep[b];
    req = '0;
    req[who] = 1'b1;
    do_txn(req, op_p, din_p, rep_p, scramble, rst_at);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    REQ = '1;
    repeat (2) @(posedge C);
    @(negedge C);
    check("reset", {GNT, DONE, OVF, BUSY, D, L, INC, SHL, SHR}, 0);
    RST = 1'b0;

    // All requesting: grants must rotate 0,1,2,3.
    for (int unsigned i = 0; i < 4; i++)
      do_txn('1, (2*N)'($urandom), (4*N)'($urandom), (3*N)'($urandom), 1'b0, 0);

    txn(1, 0, 4'hA, 7, 1'b0, 0);

    txn(0, 0, 4'hE, 0, 1'b0, 0);
    txn(0, 1, $urandom_range(0, 15), 2, 1'b0, 0);
    txn(0, 0, 4'h3, 0, 1'b0, 0);
    txn(0, 1, $urandom_range(0, 15), 2, 1'b0, 0);

    txn(2, 0, 4'b1000, 0, 1'b0, 0);
    txn(2, 2, 4'b0001, 3, 1'b0, 0);
    txn(2, 3, 4'b0000, 1, 1'b0, 0);

    // Reset in the 2nd ISSUE cycle of INC x6; pointer must return to 0.
    txn(2, 1, $urandom_range(0, 15), 5, 1'b0, 2);
    do_txn('1, (2*N)'($urandom), (4*N)'($urandom), (3*N)'($urandom), 1'b0, 0);

    for (int unsigned i = 0; i < 3; i++)
      txn(3, $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 7), 1'b0, 0);
    for (int unsigned i = 0; i < 3; i++)
      txn(3, $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 7), 1'b1, 0);

    for (int unsigned i = 0; i < 40; i++)
      do_txn(N'($urandom_range(1, (1 << N) - 1)), (2*N)'($urandom), (4*N)'($urandom),
             (3*N)'($urandom), 1'b1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
